// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file slice.
package regfile_pkg;

  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_ADDR_W = 5;
  localparam int REGFILE_SIZE   = 2 ** REGFILE_ADDR_W;

  typedef logic [REGFILE_ADDR_W-1:0] reg_idx_t;
  typedef logic [REGFILE_DATA_W-1:0] reg_word_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits with write-clear / reserve-set / flush priority and a
// running count of outstanding entries.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_0,
  input  logic [ADDR_W-1:0]      wr_addr_0,
  input  logic                   wr_en_1,
  input  logic [ADDR_W-1:0]      wr_addr_1,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  input  logic                   flush,
  output logic [(2**ADDR_W)-1:0] pend,
  output logic [ADDR_W:0]        pend_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_clr;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_next;
  logic [ADDR_W:0]  r_cnt;
  logic [ADDR_W:0]  w_inc;
  logic [ADDR_W:0]  w_dec;

  // Set is applied after clear so a new producer supersedes a retiring one.
  always_comb begin
    w_clr = '0;
    w_set = '0;
    if (wr_en_0) w_clr[wr_addr_0] = 1'b1;
    if (wr_en_1) w_clr[wr_addr_1] = 1'b1;
    if (rsv_en)  w_set[rsv_addr]  = 1'b1;
    w_next = flush ? '0 : ((r_pend & ~w_clr) | w_set);
    if (ZERO_REG != 0) w_next[0] = 1'b0;
  end

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_next[ADDR_W'(i)] && !r_pend[ADDR_W'(i)]) w_inc = w_inc + (ADDR_W+1)'(1);
      if (!w_next[ADDR_W'(i)] && r_pend[ADDR_W'(i)]) w_dec = w_dec + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_next;
      r_cnt  <= r_cnt + w_inc - w_dec;
    end
  end

  assign pend     = r_pend;
  assign pend_cnt = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// 2-read / 2-write register file with integrated pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_pend_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_pend_b,
  input  logic              wr_en_0,
  input  logic [ADDR_W-1:0] wr_addr_0,
  input  logic [DATA_W-1:0] wr_data_0,
  input  logic              wr_en_1,
  input  logic [ADDR_W-1:0] wr_addr_1,
  input  logic [DATA_W-1:0] wr_data_1,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_pend;
  logic              w_wr0_ok;
  logic              w_wr1_ok;
  logic              w_rsv_ok;

  assign w_wr0_ok = wr_en_0 && !((ZERO_REG != 0) && (wr_addr_0 == '0));
  assign w_wr1_ok = wr_en_1 && !((ZERO_REG != 0) && (wr_addr_1 == '0));
  assign w_rsv_ok = rsv_en  && !((ZERO_REG != 0) && (rsv_addr  == '0));

  // Port 1 is assigned last so it wins a same-index collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[ADDR_W'(i)] <= '0;
    end else begin
      if (w_wr0_ok) r_mem[wr_addr_0] <= wr_data_0;
      if (w_wr1_ok) r_mem[wr_addr_1] <= wr_data_1;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .wr_en_0   (w_wr0_ok),
    .wr_addr_0 (wr_addr_0),
    .wr_en_1   (w_wr1_ok),
    .wr_addr_1 (wr_addr_1),
    .rsv_en    (w_rsv_ok),
    .rsv_addr  (rsv_addr),
    .flush     (flush),
    .pend      (w_pend),
    .pend_cnt  (pend_cnt)
  );

  for (genvar g = 0; g < 2; g++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_d;
    logic              w_p;

    assign w_ra = (g == 0) ? rd_addr_a : rd_addr_b;

    always_comb begin
      w_d = r_mem[w_ra];
      w_p = w_pend[w_ra];
`ifdef REGFILE_BYPASS_EN
      if (w_wr0_ok && (wr_addr_0 == w_ra)) begin
        w_d = wr_data_0;
        w_p = rsv_en && (rsv_addr == w_ra);
      end
      if (w_wr1_ok && (wr_addr_1 == w_ra)) begin
        w_d = wr_data_1;
        w_p = rsv_en && (rsv_addr == w_ra);
      end
`endif
      if ((ZERO_REG != 0) && (w_ra == '0)) begin
        w_d = '0;
        w_p = 1'b0;
      end
      if (rst) begin
        w_d = '0;
        w_p = 1'b0;
      end
    end
  end

  assign rd_data_a = g_rd[0].w_d;
  assign rd_pend_a = g_rd[0].w_p;
  assign rd_data_b = g_rd[1].w_d;
  assign rd_pend_b = g_rd[1].w_p;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default 32x32, ZERO_REG=1).
module tb_regfile_mp;
  import regfile_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  reg_idx_t  rd_addr_a, rd_addr_b, wr_addr_0, wr_addr_1, rsv_addr;
  reg_word_t rd_data_a, rd_data_b, wr_data_0, wr_data_1;
  logic      rd_pend_a, rd_pend_b, wr_en_0, wr_en_1, rsv_en, flush;
  logic [REGFILE_ADDR_W:0] pend_cnt;

  int n_pass  = 0;
  int n_total = 0;

  regfile_mp #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .ZERO_REG (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_pend_a (rd_pend_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .rd_pend_b (rd_pend_b),
    .wr_en_0   (wr_en_0),
    .wr_addr_0 (wr_addr_0),
    .wr_data_0 (wr_data_0),
    .wr_en_1   (wr_en_1),
    .wr_addr_1 (wr_addr_1),
    .wr_data_1 (wr_data_1),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .flush     (flush),
    .pend_cnt  (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en_0 = 1'b0;
    wr_en_1 = 1'b0;
    rsv_en  = 1'b0;
    flush   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr_a = '0; rd_addr_b = '0;
    wr_addr_0 = '0; wr_addr_1 = '0; rsv_addr = '0;
    wr_data_0 = '0; wr_data_1 = '0;
    idle();

    // Reset held
    #2;
    chk("rst_data_a", rd_data_a, 0);
    chk("rst_pend_a", rd_pend_a, 0);
    chk("rst_cnt", pend_cnt, 0);
    #10 rst = 1'b0;

    // All indices read zero after reset
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = reg_idx_t'(i);
      rd_addr_b = reg_idx_t'(31 - i);
      #1;
      chk("init_data_a", rd_data_a, 0);
      chk("init_data_b", rd_data_b, 0);
      chk("init_pend_a", rd_pend_a, 0);
      chk("init_pend_b", rd_pend_b, 0);
    end
    chk("init_cnt", pend_cnt, 0);

    // Same-index dual write: port 1 wins
    tick();
    wr_en_0 = 1'b1; wr_addr_0 = 5'd5; wr_data_0 = 32'hDEADBEEF;
    wr_en_1 = 1'b1; wr_addr_1 = 5'd5; wr_data_1 = 32'h12345678;
    rd_addr_a = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_dual_pre", rd_data_a, 32'h12345678);
`else
    chk("nobyp_dual_pre", rd_data_a, 0);
`endif
    tick();
    idle();
    chk("dual_wr_p1_wins", rd_data_a, 32'h12345678);

    // Index 0 discards writes; port 1 to another index lands
    wr_en_0 = 1'b1; wr_addr_0 = 5'd0; wr_data_0 = 32'hFFFFFFFF;
    wr_en_1 = 1'b1; wr_addr_1 = 5'd6; wr_data_1 = 32'h00000066;
    tick();
    idle();
    rd_addr_a = 5'd0; rd_addr_b = 5'd6;
    #1;
    chk("zero_reg_data", rd_data_a, 0);
    chk("wr_idx6", rd_data_b, 32'h66);

    // Reserve 7, then write 7 while reserving again: stays pending
    rsv_en = 1'b1; rsv_addr = 5'd7;
    tick();
    idle();
    rd_addr_a = 5'd7;
    #1;
    chk("rsv7_pend", rd_pend_a, 1);
    chk("rsv7_cnt", pend_cnt, 1);
    wr_en_0 = 1'b1; wr_addr_0 = 5'd7; wr_data_0 = 32'hA5A5A5A5;
    rsv_en = 1'b1; rsv_addr = 5'd7;
    tick();
    idle();
    chk("rsv_wr7_pend", rd_pend_a, 1);
    chk("rsv_wr7_cnt", pend_cnt, 1);
    chk("rsv_wr7_data", rd_data_a, 32'hA5A5A5A5);

    // Plain write clears pending
    wr_en_1 = 1'b1; wr_addr_1 = 5'd7; wr_data_1 = 32'h00000077;
    tick();
    idle();
    chk("wr7_clr_pend", rd_pend_a, 0);
    chk("wr7_clr_cnt", pend_cnt, 0);

    // Index 0 is never pending
    rsv_en = 1'b1; rsv_addr = 5'd0;
    tick();
    idle();
    rd_addr_a = 5'd0;
    #1;
    chk("rsv0_pend", rd_pend_a, 0);
    chk("rsv0_cnt", pend_cnt, 0);

    // Reserve 3, 4, 9, then flush beats reserve 10; data write still occurs
    rsv_en = 1'b1; rsv_addr = 5'd3; tick();
    rsv_addr = 5'd4; tick();
    rsv_addr = 5'd9; tick();
    idle();
    rd_addr_a = 5'd3; rd_addr_b = 5'd9;
    #1;
    chk("rsv3_pend", rd_pend_a, 1);
    chk("rsv9_pend", rd_pend_b, 1);
    chk("rsv349_cnt", pend_cnt, 3);
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd10;
    wr_en_1 = 1'b1; wr_addr_1 = 5'd3; wr_data_1 = 32'h00000033;
    tick();
    idle();
    rd_addr_b = 5'd10;
    #1;
    chk("flush_cnt", pend_cnt, 0);
    chk("flush_pend3", rd_pend_a, 0);
    chk("flush_pend10", rd_pend_b, 0);
    chk("flush_wr3", rd_data_a, 32'h33);

    // Dual-port clear with simultaneous reserve elsewhere
    rsv_en = 1'b1; rsv_addr = 5'd20; tick();
    rsv_addr = 5'd21; tick();
    idle();
    chk("rsv2021_cnt", pend_cnt, 2);
    wr_en_0 = 1'b1; wr_addr_0 = 5'd20; wr_data_0 = 32'h20;
    wr_en_1 = 1'b1; wr_addr_1 = 5'd21; wr_data_1 = 32'h21;
    rsv_en = 1'b1; rsv_addr = 5'd22;
    tick();
    idle();
    rd_addr_a = 5'd20; rd_addr_b = 5'd22;
    #1;
    chk("dual_clr_cnt", pend_cnt, 1);
    chk("dual_clr_pend20", rd_pend_a, 0);
    chk("dual_clr_pend22", rd_pend_b, 1);
    wr_en_0 = 1'b1; wr_addr_0 = 5'd22; wr_data_0 = 32'h22;
    tick();
    idle();
    chk("wr22_cnt", pend_cnt, 0);

    // Same-cycle visibility of a write
    wr_en_0 = 1'b1; wr_addr_0 = 5'd12; wr_data_0 = 32'hCAFEF00D;
    rd_addr_a = 5'd12;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_data", rd_data_a, 32'hCAFEF00D);
    chk("byp_pend", rd_pend_a, 0);
`else
    chk("nobyp_old_data", rd_data_a, 0);
`endif
    tick();
    idle();
    chk("wr12_data", rd_data_a, 32'hCAFEF00D);

    // Async reset mid-cycle
    wr_en_0 = 1'b1; wr_addr_0 = 5'd2; wr_data_0 = 32'h55;
    rsv_en = 1'b1; rsv_addr = 5'd2; tick();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd3; tick();
    rsv_addr = 5'd4; tick();
    idle();
    rd_addr_a = 5'd2; rd_addr_b = 5'd3;
    #2;
    chk("pre_rst_data2", rd_data_a, 32'h55);
    chk("pre_rst_cnt", pend_cnt, 3);
    rst = 1'b1;
    #1;
    chk("async_rst_data2", rd_data_a, 0);
    chk("async_rst_pend2", rd_pend_a, 0);
    chk("async_rst_pend3", rd_pend_b, 0);
    chk("async_rst_cnt", pend_cnt, 0);
    rd_addr_b = 5'd12;
    #1;
    chk("async_rst_data12", rd_data_b, 0);
    rst = 1'b0;
    wr_en_0 = 1'b1; wr_addr_0 = 5'd2; wr_data_0 = 32'h77;
    tick();
    idle();
    chk("post_rst_wr2", rd_data_a, 32'h77);
    chk("post_rst_cnt", pend_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
